mod_counter: RTL and testbench

Parametrised modulo-N up/down counter, the generalised successor of the fixed 3-bit enable/carry up counter. It adds configurable width and modulus, a direction input, a synchronous clear and parallel load, and a choice between wrap and saturate at the end of the range. It exposes a combinational terminal-count output for cascading counters, and a registered wrap pulse for event logic. It sits beside the existing counters in the FPGA lab designs and feeds prescalers, BCD digit chains and display multiplexers.

---
 rtl/mod_counter_pkg.sv | 14 +
 rtl/mod_counter_if.sv | 24 ++
 rtl/mod_counter_incdec.sv | 31 +++
 rtl/mod_counter.sv | 70 +++++++
 tb/tb_mod_counter.sv | 131 +++++++++++++
 5 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants and elaboration-time parameter checks for mod_counter.
// No logic; functions are only evaluated on constant parameters.
package mod_counter_pkg;

    function automatic bit params_legal(input int width, input longint modulus);
        return (width >= 1) && (width <= 32) &&
               (modulus >= 2) && (modulus <= (longint'(1) << width));
    endfunction

    function automatic longint max_count(input longint modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of one counter stage; master drives controls, slave is the counter.
// Carries no flow control: every field is sampled or presented every cycle.
interface mod_counter_if #(
    parameter int WIDTH = 8
) ();
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, clr, load, load_val,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output count, tc, wrap
    );
endinterface

// File: rtl/mod_counter_incdec.sv
// Combinational step unit: wrapped next value, range-end detection and terminal count.
// Zero latency; no backpressure.
module incdec_unit #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] next_o,
    output logic             tc_o,
    output logic             at_limit_o
);
    logic at_top;
    logic at_bot;

    assign at_top     = (count_i == MAX_VAL);
    assign at_bot     = (count_i == '0);
    assign at_limit_o = up_i ? at_top : at_bot;
    assign tc_o       = en_i & at_limit_o;

    // Range ends fold back inside the modulus, never through 2**WIDTH.
    always_comb begin
        next_o = count_i;
        if (up_i) begin
            next_o = at_top ? '0 : count_i + WIDTH'(1);
        end else begin
            next_o = at_bot ? MAX_VAL : count_i - WIDTH'(1);
        end
    end
endmodule

// File: rtl/mod_counter.sv
// Modulo-MODULUS up/down counter with clear, clamped load, wrap/saturate, Tc and Wrap pulse.
// Count and Wrap update one edge after sampling controls; Tc is combinational.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = longint'(1) << WIDTH,
    parameter bit     SATURATE = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    mod_counter_if.slave bus_if
);
    if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
        $error("mod_counter: WIDTH must be 1..32 and MODULUS 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(max_count(MODULUS));

    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_d, wrap_q;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;
    logic             at_limit;
    logic             tc;

    incdec_unit #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_incdec (
        .count_i    (count_q),
        .up_i       (bus_if.up),
        .en_i       (bus_if.en),
        .next_o     (step_val),
        .tc_o       (tc),
        .at_limit_o (at_limit)
    );

    assign load_clamped = (64'(bus_if.load_val) > 64'(MAX_VAL)) ? MAX_VAL : bus_if.load_val;

    // Clear beats load beats stepping; only a real step across a range end raises Wrap.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus_if.clr) begin
            count_d = '0;
        end else if (bus_if.load) begin
            count_d = load_clamped;
        end else if (bus_if.en) begin
            if (!(at_limit && SATURATE)) begin
                count_d = step_val;
                wrap_d  = at_limit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus_if.count = count_q;
    assign bus_if.wrap  = wrap_q;
    assign bus_if.tc    = tc;
endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: wrap, saturate and cascaded instances with directed expectations.
module tb_mod_counter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_counter_if #(.WIDTH(4)) ifa ();
    mod_counter_if #(.WIDTH(4)) ifb ();
    mod_counter_if #(.WIDTH(4)) ifc ();
    mod_counter_if #(.WIDTH(4)) ifd ();

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (.clk(clk), .rst_n(rst_n), .bus_if(ifa));
    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus_if(ifb));
    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_units (.clk(clk), .rst_n(rst_n), .bus_if(ifc));
    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_tens (.clk(clk), .rst_n(rst_n), .bus_if(ifd));

    // Tens stage is enabled by the units terminal count.
    assign ifd.en       = ifc.tc;
    assign ifd.up       = 1'b1;
    assign ifd.clr      = 1'b0;
    assign ifd.load     = 1'b0;
    assign ifd.load_val = 4'd0;

    typedef struct {
        int    dut;
        int    cnt;
        bit    tc;
        bit    wrap;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one observation per cycle, away from the rising edge.
    initial begin
        exp_t e;
        int   a_cnt;
        bit   a_tc;
        bit   a_wrap;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.dut)
                    0: begin a_cnt = int'(ifa.count); a_tc = ifa.tc; a_wrap = ifa.wrap; end
                    1: begin a_cnt = int'(ifb.count); a_tc = ifb.tc; a_wrap = ifb.wrap; end
                    default: begin
                        a_cnt  = int'(ifd.count) * 10 + int'(ifc.count);
                        a_tc   = ifc.tc;
                        a_wrap = ifd.wrap;
                    end
                endcase
                check({e.tag, ".count"}, a_cnt, e.cnt);
                check({e.tag, ".tc"}, int'(a_tc), int'(e.tc));
                check({e.tag, ".wrap"}, int'(a_wrap), int'(e.wrap));
            end
        end
    end

    // Apply controls for the next edge and queue what the monitor must see this cycle.
    task automatic drv(input int dut, input bit en, input bit up, input bit clr, input bit load,
                       input int lv, input int cnt, input bit tc, input bit wrap, input string tag);
        case (dut)
            0: begin ifa.en = en; ifa.up = up; ifa.clr = clr; ifa.load = load; ifa.load_val = 4'(lv); end
            1: begin ifb.en = en; ifb.up = up; ifb.clr = clr; ifb.load = load; ifb.load_val = 4'(lv); end
            default: begin ifc.en = en; ifc.up = up; ifc.clr = clr; ifc.load = load; ifc.load_val = 4'(lv); end
        endcase
        sb_q.push_back('{dut, cnt, tc, wrap, tag});
        @(posedge clk);
        #2;
    endtask

    initial begin
        ifa.en = 1'b0; ifa.up = 1'b0; ifa.clr = 1'b0; ifa.load = 1'b0; ifa.load_val = 4'd0;
        ifb.en = 1'b0; ifb.up = 1'b0; ifb.clr = 1'b0; ifb.load = 1'b0; ifb.load_val = 4'd0;
        ifc.en = 1'b0; ifc.up = 1'b0; ifc.clr = 1'b0; ifc.load = 1'b0; ifc.load_val = 4'd0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        drv(0, 1, 1, 0, 0, 0, 0, 0, 0, "a_reset_state");
        for (int i = 1; i <= 6; i++) drv(0, 1, 1, 0, 0, 0, i, 0, 0, "a_pre_reset");
        drv(0, 0, 1, 0, 0, 0, 7, 0, 0, "a_hold7");
        rst_n = 1'b0;
        drv(0, 1, 1, 0, 0, 0, 0, 0, 0, "a_async_reset");
        rst_n = 1'b1;

        for (int i = 0; i <= 9; i++) drv(0, 1, 1, 0, 0, 0, i, (i == 9), 0, "a_up");
        drv(0, 0, 1, 0, 0, 0, 0, 0, 1, "a_up_wrap");
        drv(0, 1, 0, 0, 0, 0, 0, 1, 0, "a_down_tc");
        drv(0, 1, 0, 0, 0, 0, 9, 0, 1, "a_down_wrap");
        drv(0, 0, 0, 0, 0, 0, 8, 0, 0, "a_down_step");

        drv(0, 0, 0, 0, 1, 12, 8, 0, 0, "a_pre_clamp");
        drv(0, 0, 0, 1, 1, 5, 9, 0, 0, "a_load_clamp");
        drv(0, 1, 0, 0, 1, 9, 0, 1, 0, "a_clr_over_load");
        drv(0, 1, 1, 0, 1, 3, 9, 1, 0, "a_load_eq_wrap");
        drv(0, 0, 1, 0, 0, 0, 3, 0, 0, "a_load_over_en");

        drv(1, 0, 1, 0, 1, 9, 0, 0, 0, "b_load");
        for (int i = 0; i < 5; i++) drv(1, 1, 1, 0, 0, 0, 9, 1, 0, "b_sat_hi");
        drv(1, 1, 0, 0, 0, 0, 9, 0, 0, "b_turn");
        drv(1, 1, 0, 0, 0, 0, 8, 0, 0, "b_down8");
        drv(1, 0, 0, 1, 0, 0, 7, 0, 0, "b_down7");
        drv(1, 1, 0, 0, 0, 0, 0, 1, 0, "b_sat_lo");
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, "b_sat_lo_hold");

        for (int k = 0; k <= 100; k++)
            drv(2, (k < 100), 1, 0, 0, 0, k % 100, (k < 100) && (k % 10 == 9), (k == 100), "cascade");
        drv(2, 0, 1, 0, 0, 0, 0, 0, 0, "cascade_idle");

        for (int n = 0; n < 20 && sb_q.size() > 0; n++) @(posedge clk);
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d observations left, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
